// File: rtl/oclib_bc_tree_combiner.sv
`default_nettype none
// ============================================================================
// Module   : oclib_bc_tree_combiner
// Brief    : Merges N downstream byte-channel response streams into a single
//            upstream stream. Whole messages are arbitrated round-robin, so
//            bytes from different leaves never interleave. A stalled granted
//            input is abandoned after a programmable number of idle cycles.
// Revision : 1.0 - initial release
// ============================================================================

package oclib_pkg;
  typedef struct packed {
    logic [7:0] data;
    logic       valid;
    logic       ready;
  } bc_8b_bidi_s;
endpackage

module oclib_bc_tree_combiner #(
  parameter type BcType        = oclib_pkg::bc_8b_bidi_s,
  parameter int  Inputs        = 8,
  parameter int  MaxLength     = 120,
  parameter int  TimeoutCycles = 1024,
  parameter int  ResetPipeline = 0,
  localparam int InputsSafe    = (Inputs < 1) ? 1 : Inputs,
  localparam int GrantWidth    = (InputsSafe > 1) ? $clog2(InputsSafe) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  BcType                 downIn  [0:InputsSafe-1],
  output BcType                 downOut [0:InputsSafe-1],
  input  BcType                 upIn,
  output BcType                 upOut,
  output logic [GrantWidth-1:0] grant,
  output logic                  busy,
  output logic                  timeoutError
);

  localparam int              IdleWidth  = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam bit              TimeoutEn  = (TimeoutCycles > 0);
  localparam logic [IdleWidth-1:0] IdleLast = IdleWidth'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
  localparam logic [7:0]      MaxLen8    = 8'((MaxLength > 255) ? 255 : MaxLength);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StGrant  = 2'd1,
    StActive = 2'd2
  } state_t;

  state_t                state, state_n;
  logic [GrantWidth-1:0] grant_r, grant_n, last_grant, last_n, arb_idx;
  logic                  arb_found;
  logic [7:0]            count, count_n;
  logic [IdleWidth-1:0]  idle_cnt, idle_n;
  logic [7:0]            up_data, up_data_n;
  logic                  up_valid, up_valid_n;
  logic                  timeout_r, timeout_n;
  logic                  sel_valid, ready_g, xfer;
  logic [7:0]            sel_data;
  logic [ResetPipeline:0] rst_pipe;
  logic                  rst_int;
  logic                  unused_fields;

  // Reset asserts immediately and releases on a clock edge after the pipeline drains.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rst_pipe <= '1;
    else       rst_pipe <= rst_pipe << 1;
  end
  assign rst_int = rst_pipe[ResetPipeline];

  // Round-robin pick: first valid input after the last served one, wrapping modulo InputsSafe.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int k = 1; k <= InputsSafe; k++) begin
      logic [GrantWidth-1:0] cand;
      cand = GrantWidth'((int'(last_grant) + k) % InputsSafe);
      if (!arb_found && downIn[cand].valid) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  assign sel_valid = downIn[grant_r].valid;
  assign sel_data  = downIn[grant_r].data;
  assign ready_g   = (state != StIdle) && (!up_valid || upIn.ready);
  assign xfer      = ready_g && sel_valid;

  // Next-state, framing, timeout and output-register logic.
  always_comb begin
    state_n    = state;
    grant_n    = grant_r;
    last_n     = last_grant;
    count_n    = count;
    idle_n     = idle_cnt;
    up_valid_n = up_valid;
    up_data_n  = up_data;
    timeout_n  = 1'b0;

    if (xfer) begin
      up_valid_n = 1'b1;
      up_data_n  = sel_data;
    end else if (upIn.ready) begin
      up_valid_n = 1'b0;
    end

    case (state)
      StIdle: begin
        if (arb_found) begin
          grant_n = arb_idx;
          state_n = StGrant;
        end
      end
      StGrant: begin
        if (xfer) begin
          idle_n = '0;
          if (sel_data >= 8'd2 && sel_data <= MaxLen8) begin
            count_n = sel_data - 8'd1;
            state_n = StActive;
          end else begin
            state_n = StIdle;
            last_n  = grant_r;
          end
        end
      end
      StActive: begin
        if (xfer) begin
          idle_n = '0;
          if (count == 8'd1) begin
            state_n = StIdle;
            last_n  = grant_r;
          end else begin
            count_n = count - 8'd1;
          end
        end else if (TimeoutEn && !sel_valid) begin
          // Only source starvation counts; upstream backpressure does not.
          if (idle_cnt == IdleLast) begin
            timeout_n = 1'b1;
            state_n   = StIdle;
            last_n    = grant_r;
          end else if (idle_cnt != '1) begin
            idle_n = idle_cnt + 1'b1;
          end
        end
      end
      default: state_n = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or posedge rst_int) begin
    if (rst_int) begin
      state      <= StIdle;
      grant_r    <= '0;
      last_grant <= GrantWidth'(InputsSafe - 1);
      count      <= '0;
      idle_cnt   <= '0;
      up_valid   <= 1'b0;
      up_data    <= '0;
      timeout_r  <= 1'b0;
    end else begin
      state      <= state_n;
      grant_r    <= grant_n;
      last_grant <= last_n;
      count      <= count_n;
      idle_cnt   <= idle_n;
      up_valid   <= up_valid_n;
      up_data    <= up_data_n;
      timeout_r  <= timeout_n;
    end
  end

  // Per-input ready goes only to the granted leaf; data/valid toward leaves are unused.
  always_comb begin
    for (int i = 0; i < InputsSafe; i++) begin
      downOut[i]       = '0;
      downOut[i].ready = (GrantWidth'(i) == grant_r) && ready_g;
    end
  end

  // Upstream carries data/valid only.
  always_comb begin
    upOut       = '0;
    upOut.data  = up_data;
    upOut.valid = up_valid;
  end

  assign grant        = grant_r;
  assign busy         = (state != StIdle);
  assign timeoutError = timeout_r;

  // Fields of the bidirectional struct that this direction ignores.
  always_comb begin
    unused_fields = upIn.valid ^ (^upIn.data);
    for (int i = 0; i < InputsSafe; i++) begin
      unused_fields = unused_fields ^ downIn[i].ready;
    end
  end

endmodule

`default_nettype wire
